// File: rtl/rv_hazard_pkg.sv
// Hazard unit shared types: opcodes, forwarding selects and the
// shadow-entry record tracked for the EX, MEM and WB stages.
package rv_hazard_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [1:0] FRWD_REG = 2'b00;
    localparam logic [1:0] FRWD_MEM = 2'b01;
    localparam logic [1:0] FRWD_WB  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       is_load;
        logic       is_md;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } shadow_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       use1;
        logic       use2;
        logic       wr;
        logic       is_load;
        logic       is_md;
        logic       is_div;
    } dec_t;

    localparam shadow_t SHADOW_NONE = '0;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] frwd_sel(
        logic       use_x,
        logic [4:0] rs,
        shadow_t    mem,
        shadow_t    wb
    );
        if (use_x && mem.valid && mem.wr && mem.rd == rs)
            return FRWD_MEM;
        if (use_x && wb.valid && wb.wr && wb.rd == rs)
            return FRWD_WB;
        return FRWD_REG;
    endfunction

endpackage

// File: rtl/rv_hazard_if.sv
// ID-side hazard bundle: instruction in, stall/bubble/forward controls out.
// master = pipeline datapath, slave = hazard unit.
interface rv_hazard_if;

    logic [31:0] ID_INSTRUCTION;
    logic        ID_VALID;
    logic        EX_FLUSH;
    logic        STALL_IF_ID;
    logic        STALL_ID_EX;
    logic        BUBBLE_EX;
    logic        BUBBLE_MEM;
    logic [1:0]  FRWD_RS1;
    logic [1:0]  FRWD_RS2;
    logic        MD_BUSY;

    modport master (
        output ID_INSTRUCTION, ID_VALID, EX_FLUSH,
        input  STALL_IF_ID, STALL_ID_EX, BUBBLE_EX, BUBBLE_MEM,
        input  FRWD_RS1, FRWD_RS2, MD_BUSY
    );

    modport slave (
        input  ID_INSTRUCTION, ID_VALID, EX_FLUSH,
        output STALL_IF_ID, STALL_ID_EX, BUBBLE_EX, BUBBLE_MEM,
        output FRWD_RS1, FRWD_RS2, MD_BUSY
    );

endinterface

// File: rtl/rv_hazard_decode.sv
// Register-usage decode of one RV32IM instruction.
// Ports: instr_i (32-bit instruction) -> dec_o (regs, use/write/load/M flags).
module rv_hazard_decode
    import rv_hazard_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;

    assign opcode = instr_i[6:0];
    assign funct7 = instr_i[31:25];
    assign funct3 = instr_i[14:12];

    always_comb begin
        dec_o     = '0;
        dec_o.rd  = instr_i[11:7];
        dec_o.rs1 = instr_i[19:15];
        dec_o.rs2 = instr_i[24:20];
        unique case (opcode)
            OP_R: begin
                dec_o.use1  = 1'b1;
                dec_o.use2  = 1'b1;
                dec_o.wr    = 1'b1;
                dec_o.is_md = (funct7 == FUNCT7_MULDIV);
            end
            OP_IMM, OP_JALR: begin
                dec_o.use1 = 1'b1;
                dec_o.wr   = 1'b1;
            end
            OP_LOAD: begin
                dec_o.use1    = 1'b1;
                dec_o.wr      = 1'b1;
                dec_o.is_load = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                dec_o.use1 = 1'b1;
                dec_o.use2 = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUIPC: begin
                dec_o.wr = 1'b1;
            end
            default: ;
        endcase
        // x0 is never a real destination
        dec_o.wr     = dec_o.wr && (dec_o.rd != 5'd0);
        // funct3 100..111 are DIV/DIVU/REM/REMU
        dec_o.is_div = dec_o.is_md && (funct3 >= 3'd4);
    end

endmodule

// File: rtl/rv_hazard_unit.sv
// Hazard unit beside ID: load-use bubbles, M-op front-end freeze and EX forwarding.
// Ports: CLK, RESET (sync, active high), hz (rv_hazard_if.slave).
module rv_hazard_unit
    import rv_hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    rv_hazard_if.slave hz
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    dec_t             id_dec;
    shadow_t          id_ent;
    shadow_t          ex_q,  ex_d;
    shadow_t          mem_q, mem_d;
    shadow_t          wb_q,  wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_busy;
    logic             lu_hit;
    logic             ex_kill;

    rv_hazard_decode u_dec (
        .instr_i (hz.ID_INSTRUCTION),
        .dec_o   (id_dec)
    );

    always_comb begin
        id_ent         = SHADOW_NONE;
        id_ent.valid   = hz.ID_VALID;
        id_ent.rd      = id_dec.rd;
        id_ent.rs1     = id_dec.rs1;
        id_ent.rs2     = id_dec.rs2;
        id_ent.wr      = hz.ID_VALID && id_dec.wr;
        id_ent.is_load = hz.ID_VALID && id_dec.is_load;
        id_ent.is_md   = hz.ID_VALID && id_dec.is_md;
        id_ent.use1    = hz.ID_VALID && id_dec.use1;
        id_ent.use2    = hz.ID_VALID && id_dec.use2;
    end

    assign md_busy = (cnt_q != '0);

    // wr already excludes rd == x0, so x0 consumers never stall
    assign lu_hit = ex_q.valid && ex_q.is_load && ex_q.wr &&
                    ((id_ent.use1 && (ex_q.rd == id_ent.rs1)) ||
                     (id_ent.use2 && (ex_q.rd == id_ent.rs2)));

    assign ex_kill = hz.EX_FLUSH || lu_hit;

    always_comb begin
        hz.STALL_IF_ID = 1'b0;
        hz.STALL_ID_EX = 1'b0;
        hz.BUBBLE_EX   = 1'b0;
        hz.BUBBLE_MEM  = 1'b0;
        hz.MD_BUSY     = 1'b0;
        hz.FRWD_RS1    = FRWD_REG;
        hz.FRWD_RS2    = FRWD_REG;
        if (!RESET) begin
            hz.FRWD_RS1 = frwd_sel(ex_q.use1, ex_q.rs1, mem_q, wb_q);
            hz.FRWD_RS2 = frwd_sel(ex_q.use2, ex_q.rs2, mem_q, wb_q);
            hz.MD_BUSY  = md_busy;
            if (md_busy) begin
                hz.STALL_IF_ID = 1'b1;
                hz.STALL_ID_EX = 1'b1;
                hz.BUBBLE_MEM  = 1'b1;
            end else if (!hz.EX_FLUSH && lu_hit) begin
                hz.STALL_IF_ID = 1'b1;
                hz.BUBBLE_EX   = 1'b1;
            end
        end
    end

    // While an M-op is busy EX holds and MEM/WB drain behind it.
    always_comb begin
        wb_d  = mem_q;
        mem_d = md_busy ? SHADOW_NONE : ex_q;
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (md_busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            ex_d  = ex_kill ? SHADOW_NONE : id_ent;
            cnt_d = '0;
            if (!ex_kill && id_ent.is_md)
                cnt_d = id_dec.is_div ? DIV_LOAD : MUL_LOAD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_q  <= SHADOW_NONE;
            mem_q <= SHADOW_NONE;
            wb_q  <= SHADOW_NONE;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Self-checking bench for rv_hazard_unit: directed hazard sequences,
// then random instruction streams against a stage-occupancy reference model.
module tb_rv_hazard_unit;

    localparam int MULC = 1;
    localparam int DIVC = 33;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_hazard_if hz();

    rv_hazard_unit #(
        .MUL_CYCLES (MULC),
        .DIV_CYCLES (DIVC),
        .CNT_W      (6)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .hz    (hz.slave)
    );

    typedef struct {
        bit v;
        int rd, rs1, rs2;
        bit wr, ld, md, u1, u2;
        int occ;
    } mi_t;

    mi_t m_ex, m_mem, m_wb;
    int  m_left;
    int  checks = 0;
    int  fails  = 0;

    bit  e_sif, e_sidex, e_bex, e_bmem, e_busy;
    int  e_f1, e_f2;
    logic       d_sif, d_bex, d_busy;
    logic [1:0] d_f1;
    int  n_sif, n_sidex, n_bex, n_bmem, n_busy;
    logic [2:0] f1_seen, f2_seen;
    logic [31:0] prog[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mi_t bdec(logic [31:0] ins, bit v);
        mi_t m;
        logic [6:0] op;
        m  = '{default: 0};
        op = ins[6:0];
        if (!v) return m;
        m.v   = 1;
        m.rd  = int'(ins[11:7]);
        m.rs1 = int'(ins[19:15]);
        m.rs2 = int'(ins[24:20]);
        m.u1  = op inside {7'b0110011, 7'b0010011, 7'b0000011,
                           7'b0100011, 7'b1100011, 7'b1100111};
        m.u2  = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        m.wr  = (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                            7'b0010111, 7'b1101111, 7'b1100111}) && m.rd != 0;
        m.ld  = (op == 7'b0000011);
        m.md  = (op == 7'b0110011) && (ins[31:25] == 7'b0000001);
        m.occ = !m.md ? 1 : (ins[14] ? DIVC : MULC);
        return m;
    endfunction

    function automatic int fsel(bit use_x, int rs);
        if (use_x && m_mem.v && m_mem.wr && m_mem.rd == rs) return 1;
        if (use_x && m_wb.v && m_wb.wr && m_wb.rd == rs) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] r_ins(logic [6:0] f7, int rd, int rs1,
                                          int rs2, logic [2:0] f3);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(int rd, int rs1, int imm);
        return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction

    function automatic logic [31:0] sw(int rs2, int rs1, int imm);
        logic [11:0] i12;
        i12 = 12'(imm);
        return {i12[11:5], 5'(rs2), 5'(rs1), 3'b010, i12[4:0], 7'b0100011};
    endfunction

    task automatic clr();
        n_sif = 0; n_sidex = 0; n_bex = 0; n_bmem = 0; n_busy = 0;
        f1_seen = '0; f2_seen = '0;
    endtask

    task automatic cycle(logic [31:0] ins, bit vld, bit fl, bit r);
        mi_t id;
        bit  busy, lu;
        @(negedge clk);
        hz.ID_INSTRUCTION = ins;
        hz.ID_VALID       = vld;
        hz.EX_FLUSH       = fl;
        rst               = r;
        #1;
        id   = bdec(ins, vld);
        busy = m_left > 0;
        lu   = m_ex.v && m_ex.ld && m_ex.wr &&
               ((id.u1 && id.rs1 == m_ex.rd) || (id.u2 && id.rs2 == m_ex.rd));
        e_sidex = !r && busy;
        e_bmem  = e_sidex;
        e_busy  = e_sidex;
        e_bex   = !r && !busy && !fl && lu;
        e_sif   = e_sidex || e_bex;
        e_f1    = r ? 0 : fsel(m_ex.u1, m_ex.rs1);
        e_f2    = r ? 0 : fsel(m_ex.u2, m_ex.rs2);
        d_sif  = hz.STALL_IF_ID;
        d_bex  = hz.BUBBLE_EX;
        d_busy = hz.MD_BUSY;
        d_f1   = hz.FRWD_RS1;
        n_sif   += int'(hz.STALL_IF_ID === 1'b1);
        n_sidex += int'(hz.STALL_ID_EX === 1'b1);
        n_bex   += int'(hz.BUBBLE_EX === 1'b1);
        n_bmem  += int'(hz.BUBBLE_MEM === 1'b1);
        n_busy  += int'(hz.MD_BUSY === 1'b1);
        if (hz.FRWD_RS1 < 2'd3) f1_seen[hz.FRWD_RS1] = 1'b1;
        if (hz.FRWD_RS2 < 2'd3) f2_seen[hz.FRWD_RS2] = 1'b1;
        chk("stall_if_id", 32'(hz.STALL_IF_ID), 32'(e_sif));
        chk("stall_id_ex", 32'(hz.STALL_ID_EX), 32'(e_sidex));
        chk("bubble_ex",   32'(hz.BUBBLE_EX),   32'(e_bex));
        chk("bubble_mem",  32'(hz.BUBBLE_MEM),  32'(e_bmem));
        chk("md_busy",     32'(hz.MD_BUSY),     32'(e_busy));
        chk("frwd_rs1",    32'(hz.FRWD_RS1),    32'(e_f1));
        chk("frwd_rs2",    32'(hz.FRWD_RS2),    32'(e_f2));
        @(posedge clk);
        if (r) begin
            m_ex   = '{default: 0};
            m_mem  = '{default: 0};
            m_wb   = '{default: 0};
            m_left = 0;
        end else begin
            m_wb = m_mem;
            if (busy) m_mem = '{default: 0};
            else      m_mem = m_ex;
            if (busy) begin
                m_left--;
            end else begin
                if (fl || lu) m_ex = '{default: 0};
                else          m_ex = id;
                m_left = m_ex.v ? m_ex.occ - 1 : 0;
            end
        end
    endtask

    task automatic run_prog();
        int guard;
        guard = 0;
        while (prog.size() > 0 && guard < 500) begin
            cycle(prog[0], 1'b1, 1'b0, 1'b0);
            if (!e_sif) void'(prog.pop_front());
            guard++;
        end
        if (prog.size() > 0) begin
            chk("prog_timeout", 32'(prog.size()), 32'd0);
            prog.delete();
        end
    endtask

    localparam logic [6:0] OPS [11] = '{
        7'b0110011, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011,
        7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
        7'b0010111
    };

    function automatic logic [31:0] rnd_ins();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 11);
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        if (k < 11) w[6:0] = OPS[k];
        if (w[6:0] == 7'b0110011) begin
            if ($urandom_range(0, 7) == 0) w[31:25] = 7'h01;
            else w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return w;
    endfunction

    initial begin
        logic [31:0] cur;
        bit vld, fl, r, hold;
        m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
        m_left = 0;
        hz.ID_INSTRUCTION = NOP;
        hz.ID_VALID = 1'b0;
        hz.EX_FLUSH = 1'b0;
        clr();

        repeat (2) cycle(NOP, 1'b0, 1'b0, 1'b1);
        cycle(NOP, 1'b0, 1'b0, 1'b0);
        chk("rst_busy", 32'(d_busy), 32'd0);
        chk("rst_stall", 32'(d_sif), 32'd0);

        clr();
        prog = '{lw(5, 1, 0), r_ins(7'h00, 6, 5, 2, 3'd0), NOP, NOP, NOP};
        run_prog();
        chk("lu_stall_cnt", 32'(n_sif), 32'd1);
        chk("lu_bub_cnt", 32'(n_bex), 32'd1);
        chk("lu_f1_seen", 32'(f1_seen), 32'b101);

        clr();
        prog = '{lw(5, 1, 0), sw(5, 3, 4), NOP, NOP, NOP};
        run_prog();
        chk("st_bub_cnt", 32'(n_bex), 32'd1);
        chk("st_f2_seen", 32'(f2_seen), 32'b101);

        clr();
        prog = '{lw(0, 1, 0), r_ins(7'h00, 6, 0, 0, 3'd0), NOP, NOP, NOP};
        run_prog();
        chk("x0_stall_cnt", 32'(n_sif), 32'd0);
        chk("x0_f1_seen", 32'(f1_seen), 32'b001);

        clr();
        prog = '{r_ins(7'h00, 7, 1, 2, 3'd0), r_ins(7'h20, 8, 7, 7, 3'd0),
                 NOP, NOP, NOP};
        run_prog();
        chk("raw_stall_cnt", 32'(n_sif), 32'd0);
        chk("raw_f1_seen", 32'(f1_seen), 32'b011);
        chk("raw_f2_seen", 32'(f2_seen), 32'b011);

        clr();
        prog = '{r_ins(7'h00, 7, 1, 2, 3'd0), NOP,
                 r_ins(7'h20, 8, 7, 7, 3'd0), NOP, NOP, NOP};
        run_prog();
        chk("wb_f1_seen", 32'(f1_seen), 32'b101);
        chk("wb_f2_seen", 32'(f2_seen), 32'b101);

        clr();
        prog = '{r_ins(7'h01, 9, 3, 4, 3'b100), r_ins(7'h00, 10, 9, 1, 3'd0),
                 NOP, NOP, NOP};
        run_prog();
        chk("div_busy_cnt", 32'(n_busy), 32'd32);
        chk("div_sif_cnt", 32'(n_sif), 32'd32);
        chk("div_sidex_cnt", 32'(n_sidex), 32'd32);
        chk("div_bmem_cnt", 32'(n_bmem), 32'd32);
        chk("div_f1_seen", 32'(f1_seen), 32'b011);

        cycle(lw(5, 1, 0), 1'b1, 1'b0, 1'b0);
        cycle(r_ins(7'h00, 6, 5, 2, 3'd0), 1'b1, 1'b1, 1'b0);
        chk("fl_stall", 32'(d_sif), 32'd0);
        chk("fl_bub", 32'(d_bex), 32'd0);
        cycle(r_ins(7'h00, 6, 5, 2, 3'd0), 1'b1, 1'b0, 1'b0);
        chk("fl_ex_f1", 32'(d_f1), 32'd0);
        chk("fl_ex_nolu", 32'(d_sif), 32'd0);
        repeat (3) cycle(NOP, 1'b1, 1'b0, 1'b0);

        cycle(r_ins(7'h01, 9, 3, 4, 3'b100), 1'b1, 1'b0, 1'b0);
        repeat (10) cycle(r_ins(7'h00, 10, 9, 1, 3'd0), 1'b1, 1'b0, 1'b0);
        cycle(r_ins(7'h00, 10, 9, 1, 3'd0), 1'b1, 1'b0, 1'b1);
        cycle(r_ins(7'h01, 11, 1, 2, 3'd0), 1'b1, 1'b0, 1'b0);
        chk("rstmid_busy", 32'(d_busy), 32'd0);
        chk("rstmid_stall", 32'(d_sif), 32'd0);
        chk("rstmid_f1", 32'(d_f1), 32'd0);
        cycle(r_ins(7'h00, 12, 11, 1, 3'd0), 1'b1, 1'b0, 1'b0);
        chk("mul_no_stall", 32'(d_sif), 32'd0);
        chk("mul_no_busy", 32'(d_busy), 32'd0);
        cycle(NOP, 1'b1, 1'b0, 1'b0);
        chk("mul_fwd_f1", 32'(d_f1), 32'd1);

        cur  = NOP;
        vld  = 1'b1;
        hold = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (!hold) begin
                cur = rnd_ins();
                vld = ($urandom_range(0, 7) != 0);
            end
            fl = (m_left == 0) && ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 299) == 0);
            cycle(cur, vld, fl, r);
            hold = e_sif && !r;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
